// File: rtl/rc5_core.sv
// RC5 block cipher core: one full round per clock, encrypt and decrypt,
// with a writable expanded-key S-table and a valid/ready result handshake.
module rc5_core #(
  parameter int W          = 32,
  parameter int MAX_ROUNDS = 12,
  localparam int T         = 2 * MAX_ROUNDS + 2,
  localparam int AW        = $clog2(T)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_we,
  input  logic [AW-1:0]   s_addr,
  input  logic [W-1:0]    s_wdata,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mode,
  input  logic [7:0]      in_rounds,
  input  logic [2*W-1:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  out_data,
  output logic            out_err
);

  localparam int LGW = $clog2(W);
  localparam logic [7:0] MAXR   = 8'(MAX_ROUNDS);
  localparam logic [AW:0] T_LIM = (AW+1)'(T);

  typedef enum logic [1:0] {IDLE, WHITEN, ROUND, DONE} state_t;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LGW-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} << n;
    return t[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LGW-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} >> n;
    return t[W-1:0];
  endfunction

  state_t         state_q;
  logic [W-1:0]   s_q [T];
  logic [W-1:0]   a_q, b_q;
  logic [7:0]     idx_q, rounds_q;
  logic           mode_q, err_q;
  logic           out_valid_q, out_err_q;
  logic [2*W-1:0] out_data_q;

  logic [AW-1:0]  ka, kb;
  logic [W-1:0]   ke, ko;
  logic [W-1:0]   enc_a, enc_b, dec_a, dec_b;
  logic [W-1:0]   rnd_a_d, rnd_b_d, wht_a_d, wht_b_d;
  logic           wr_ok;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

  // Round keys for the current index: S[2i] and S[2i+1]
  always_comb begin
    ka      = AW'({idx_q, 1'b0});
    kb      = {ka[AW-1:1], 1'b1};
    ke      = s_q[ka];
    ko      = s_q[kb];
    enc_a   = rotl(a_q ^ b_q, b_q[LGW-1:0]) + ke;
    enc_b   = rotl(b_q ^ enc_a, enc_a[LGW-1:0]) + ko;
    dec_b   = rotr(b_q - ko, a_q[LGW-1:0]) ^ a_q;
    dec_a   = rotr(a_q - ke, dec_b[LGW-1:0]) ^ dec_b;
    rnd_a_d = mode_q ? dec_a : enc_a;
    rnd_b_d = mode_q ? dec_b : enc_b;
    wht_a_d = mode_q ? (a_q - s_q[0]) : (a_q + s_q[0]);
    wht_b_d = mode_q ? (b_q - s_q[1]) : (b_q + s_q[1]);
  end

  // Key table only changes while no operation is consuming it
  assign wr_ok = (state_q == IDLE) || (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst && s_we && wr_ok && ({1'b0, s_addr} < T_LIM))
      s_q[s_addr] <= s_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mode_q   <= in_mode;
            rounds_q <= in_rounds;
            a_q      <= in_data[W-1:0];
            b_q      <= in_data[2*W-1:W];
            err_q    <= (in_rounds > MAXR);
            // Decrypt walks the rounds first; errors pass through WHITEN untouched
            if (in_mode && in_rounds != 8'd0 && in_rounds <= MAXR) begin
              idx_q   <= in_rounds;
              state_q <= ROUND;
            end else begin
              idx_q   <= 8'd1;
              state_q <= WHITEN;
            end
          end
        end
        WHITEN: begin
          if (err_q) begin
            out_data_q  <= {b_q, a_q};
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            a_q <= wht_a_d;
            b_q <= wht_b_d;
            if (mode_q || rounds_q == 8'd0) begin
              out_data_q  <= {wht_b_d, wht_a_d};
              out_err_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= ROUND;
            end
          end
        end
        ROUND: begin
          a_q <= rnd_a_d;
          b_q <= rnd_b_d;
          if (mode_q) begin
            if (idx_q == 8'd1) state_q <= WHITEN;
            else               idx_q   <= idx_q - 8'd1;
          end else if (idx_q == rounds_q) begin
            out_data_q  <= {rnd_b_d, rnd_a_d};
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + 8'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc5_core.sv
// Directed bench for rc5_core (W=32, MAX_ROUNDS=12) using the published
// all-zero-key RC5-32/12/16 vector plus small hand-computed cases.
module tb_rc5_core;
  localparam int W  = 32;
  localparam int MR = 12;
  localparam int T  = 2 * MR + 2;
  localparam int AW = $clog2(T);

  logic          clk = 1'b0;
  logic          rst;
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [W-1:0]  s_wdata;
  logic          in_valid, in_ready, in_mode;
  logic [7:0]    in_rounds;
  logic [63:0]   in_data;
  logic          out_valid, out_ready, out_err;
  logic [63:0]   out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rc5_core #(.W(W), .MAX_ROUNDS(MR)) dut (
    .clk(clk), .rst(rst),
    .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_rounds(in_rounds), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rol32(input logic [31:0] x, input int n);
    int k;
    k = n % 32;
    return (k == 0) ? x : ((x << k) | (x >> (32 - k)));
  endfunction

  // Called right after a negedge; any s_we set by the caller lands on the accept edge.
  task automatic run(input logic mode, input logic [7:0] r, input logic [63:0] d,
                     input logic ack, output logic [63:0] res, output logic err,
                     output int lat);
    in_valid  = 1'b1;
    in_mode   = mode;
    in_rounds = r;
    in_data   = d;
    @(negedge clk);
    in_valid = 1'b0;
    s_we     = 1'b0;
    lat      = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = out_data;
    err = out_err;
    if (ack) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  logic [31:0] ks [T];
  logic [31:0] kl [4];
  logic [63:0] res, ct, held;
  logic        err;
  int          lat;

  initial begin
    logic [31:0] a, b;
    int i, j;
    rst = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
    in_valid = 1'b0; in_mode = 1'b0; in_rounds = '0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    rst = 1'b1;

    // RC5-32 key expansion for a 16-byte all-zero key
    ks[0] = 32'hB7E15163;
    for (int k = 1; k < T; k++) ks[k] = ks[k-1] + 32'h9E3779B9;
    for (int k = 0; k < 4; k++) kl[k] = 32'd0;
    a = 0; b = 0; i = 0; j = 0;
    for (int k = 0; k < 3 * T; k++) begin
      ks[i] = rol32(ks[i] + a + b, 3);
      a     = ks[i];
      kl[j] = rol32(kl[j] + a + b, int'((a + b) & 32'd31));
      b     = kl[j];
      i = (i + 1) % T;
      j = (j + 1) % 4;
    end
    for (int k = 0; k < T; k++) begin
      s_we = 1'b1; s_addr = AW'(k); s_wdata = ks[k];
      @(negedge clk);
    end
    s_we = 1'b0;

    run(1'b0, 8'd12, 64'd0, 1'b1, ct, err, lat);
    check("enc12_lat", 64'(lat), 64'd13);
    check("enc12_data", ct, {32'h6D8F4B15, 32'hEEDBA521});
    check("enc12_err", 64'(err), 64'd0);

    run(1'b1, 8'd12, {32'h6D8F4B15, 32'hEEDBA521}, 1'b1, res, err, lat);
    check("dec12_lat", 64'(lat), 64'd13);
    check("dec12_data", res, 64'd0);
    check("dec12_err", 64'(err), 64'd0);

    run(1'b0, 8'd5, {32'hCAFEBABE, 32'h01234567}, 1'b1, ct, err, lat);
    check("enc5_lat", 64'(lat), 64'd6);
    run(1'b1, 8'd5, ct, 1'b1, res, err, lat);
    check("dec5_roundtrip", res, {32'hCAFEBABE, 32'h01234567});

    s_we = 1'b1; s_addr = 0; s_wdata = 32'd1; @(negedge clk);
    s_addr = 1; s_wdata = 32'd2; @(negedge clk);
    s_we = 1'b0;
    run(1'b0, 8'd0, {32'd7, 32'd5}, 1'b1, res, err, lat);
    check("enc0_lat", 64'(lat), 64'd1);
    check("enc0_data", res, {32'd9, 32'd6});
    run(1'b1, 8'd0, {32'd9, 32'd6}, 1'b1, res, err, lat);
    check("dec0_lat", 64'(lat), 64'd1);
    check("dec0_data", res, {32'd7, 32'd5});

    run(1'b0, 8'd13, {32'h12345678, 32'h9ABCDEF0}, 1'b1, res, err, lat);
    check("err13_lat", 64'(lat), 64'd1);
    check("err13_err", 64'(err), 64'd1);
    check("err13_data", res, {32'h12345678, 32'h9ABCDEF0});
    run(1'b1, 8'd255, {32'hA5A5A5A5, 32'h0F0F0F0F}, 1'b1, res, err, lat);
    check("err255_err", 64'(err), 64'd1);
    check("err255_data", res, {32'hA5A5A5A5, 32'h0F0F0F0F});

    run(1'b0, 8'd0, {32'd7, 32'd5}, 1'b0, held, err, lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", out_data, {32'd9, 32'd6});
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_valid", 64'(out_valid), 64'd0);

    in_valid = 1'b1; in_mode = 1'b0; in_rounds = 8'd12; in_data = 64'h1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    s_we = 1'b1; s_addr = 1; s_wdata = 32'hDEADBEEF;
    @(negedge clk);
    s_we = 1'b0;
    check("midround_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_data", out_data, 64'd0);
    check("abort_err", 64'(out_err), 64'd0);
    rst = 1'b1;
    run(1'b0, 8'd0, {32'd7, 32'd5}, 1'b1, res, err, lat);
    check("s_write_in_round_ignored", res, {32'd9, 32'd6});

    s_we = 1'b1; s_addr = 0; s_wdata = 32'd10;
    run(1'b0, 8'd0, {32'd7, 32'd5}, 1'b1, res, err, lat);
    check("write_on_accept", res, {32'd9, 32'd15});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rc5_core.md
RC5_CORE -- requirements
Module: rc5_core

Interface
REQ-001 SHALL have parameter W, default 32, meaning word width; legal values 16, 32, 64; block width 2W.
REQ-002 SHALL have parameter MAX_ROUNDS, default 12, meaning largest supported round count, range 1..255; the S-table holds T = 2*MAX_ROUNDS+2 words.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have ports s_we (in, 1), s_addr (in, clog2(T)) and s_wdata (in, W): write port for the expanded-key S-table.
REQ-006 SHALL have ports in_valid (in, 1) and in_ready (out, 1): command handshake.
REQ-007 SHALL have port in_mode, input, 1 bit: 0 = encrypt, 1 = decrypt.
REQ-008 SHALL have port in_rounds, input, 8 bits: round count r, not zero-indexed.
REQ-009 SHALL have port in_data, input, 2W bits: A = [W-1:0], B = [2W-1:W].
REQ-010 SHALL have ports out_valid (out, 1) and out_ready (in, 1): result handshake.
REQ-011 SHALL have ports out_data (out, 2W), with the same packing as in_data, and out_err (out, 1).

Function
REQ-012 SHALL implement the FSM states IDLE, WHITEN, ROUND and DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE; a command is accepted on an edge where in_valid & in_ready = 1, and in_mode, in_rounds and in_data are captured on that edge.
REQ-014 SHALL, on an encrypt accept, run WHITEN (A += S[0], B += S[1]), then r ROUND cycles, then DONE.
REQ-015 SHALL, in encrypt ROUND i = 1..r, compute A' = ((A ^ B) <<< B) + S[2i], then B' = ((B ^ A') <<< A') + S[2i+1], as one full round per cycle.
REQ-016 SHALL, on a decrypt accept, run r ROUND cycles with i = r down to 1, then WHITEN, then DONE.
REQ-017 SHALL, in decrypt ROUND i, compute B' = ((B - S[2i+1]) >>> A) ^ A, then A' = ((A - S[2i]) >>> B') ^ B'.
REQ-018 SHALL, in decrypt WHITEN, compute B -= S[1] and A -= S[0].
REQ-019 SHALL use only the low log2(W) bits of the rotate operand as the rotation amount; all add and subtract operations are modulo 2^W.
REQ-020 SHALL treat r = 0 as WHITEN only, going directly to DONE.
REQ-021 SHALL, when r > MAX_ROUNDS, skip processing, go to DONE on the next edge, set out_err = 1, and set out_data = the captured in_data unchanged.
REQ-022 SHALL give a latency of r+1 processing cycles: accept on edge E0 results in out_valid = 1 after edge E0+r+1.
REQ-023 SHALL, in DONE, hold out_valid = 1 with out_data and out_err stable until out_ready = 1, then return to IDLE on that edge; there is one IDLE cycle between commands.
REQ-024 SHALL drive out_valid = 0 in every state except DONE.
REQ-025 SHALL commit an S-table write only when s_we = 1 and the FSM is in IDLE or DONE; writes in WHITEN or ROUND are ignored.
REQ-026 SHALL make a write on the same edge as an accept visible to that operation.
REQ-027 SHALL ignore an s_addr >= T.
REQ-028 SHALL register out_data and out_err; no combinational path from in_* to out_*.

Reset
REQ-029 SHALL, when rst = 0 at a rising edge, set the FSM to IDLE, out_valid = 0, out_err = 0 and out_data = 0, aborting any operation in flight with no partial result emitted.
REQ-030 SHALL NOT reset the S-table contents (they are retained); the internal A/B working registers are also not reset.
REQ-031 SHALL give rst priority over every other event on the same edge, including accept, writes and the out_ready handshake.

Verification
REQ-032 SHALL cover: W=32, r=12, S loaded from the key-expansion model for an all-zero 16-byte key, encrypt A=0, B=0 -> out_data A=0xEEDBA521, B=0x6D8F4B15, out_valid 13 cycles after accept.
REQ-033 SHALL cover: the same S and ciphertext with decrypt, r=12 -> A=0, B=0, out_err=0.
REQ-034 SHALL cover: S[0]=1, S[1]=2, encrypt r=0, A=5, B=7 -> A=6, B=9 after 1 cycle; decrypt of that result -> A=5, B=7.
REQ-035 SHALL cover: MAX_ROUNDS=12, in_rounds=13 -> out_err=1 and out_data = in_data, one cycle after accept.
REQ-036 SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_valid and out_data stable throughout, in_ready=0; release -> IDLE.
REQ-037 SHALL cover: rst=0 asserted mid-ROUND -> next cycle in IDLE with out_valid=0, out_data=0; an S-table write attempted during ROUND -> the table is unchanged.
